// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts
// one byte plus odd parity out on device clock falls and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int HW      = FILTER_LEN - 1;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  // index 0 = clock line, index 1 = data line
  logic [1:0]         sync1, sync2, filt, filt_n;
  logic [1:0][HW-1:0] hist;
  logic               fall;
  logic               clk_f, dat_f;

  assign clk_f = filt[0];
  assign dat_f = filt[1];

  always_comb begin
    filt_n = filt;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2[i] && hist[i] == '1)
        filt_n[i] = 1'b1;
      else if (!sync2[i] && hist[i] == '0)
        filt_n[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      hist  <= '1;
      filt  <= '1;
      fall  <= 1'b0;
    end else begin
      sync1 <= {ps2_data_in, ps2_clk_in};
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++)
        hist[i] <= (hist[i] << 1) | HW'(sync2[i]);
      filt <= filt_n;
      fall <= filt[0] & ~filt_n[0];
    end
  end

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    idx, idx_n;
  logic [7:0]    shreg;
  logic          par, nak, nak_n, accept;
  logic          clk_oe_n, data_oe_n, done_n, ack_err_n, to_n, ready_n, busy_n;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    nak_n     = nak;
    clk_oe_n  = 1'b0;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    ack_err_n = 1'b0;
    to_n      = 1'b0;
    accept    = tx_valid && tx_ready;
    cnt_inc   = cnt + CW'(1);
    case (state)
      IDLE: begin
        data_oe_n = 1'b0;
        if (accept) begin
          state_n   = INHIBIT;
          cnt_n     = '0;
          nak_n     = 1'b0;
          clk_oe_n  = 1'b1;
          data_oe_n = (INHIBIT_CYCLES == 1);
        end
      end
      INHIBIT: begin
        if (cnt == INH_LAST) begin
          state_n   = RTS;
          cnt_n     = '0;
          data_oe_n = 1'b1;
        end else begin
          cnt_n     = cnt_inc;
          clk_oe_n  = 1'b1;
          data_oe_n = (cnt_inc == INH_LAST);
        end
      end
      default: begin
        cnt_n = fall ? '0 : cnt_inc;
        case (state)
          RTS: if (fall) begin
            data_oe_n = ~shreg[0];
            idx_n     = 4'd1;
            state_n   = DATA;
          end
          DATA: if (fall) begin
            if (idx == 4'd8) begin
              data_oe_n = ~par;
              state_n   = PARITY;
            end else begin
              data_oe_n = ~shreg[idx[2:0]];
              idx_n     = idx + 4'd1;
            end
          end
          PARITY: if (fall) begin
            data_oe_n = 1'b0;
            state_n   = STOP;
          end
          STOP: if (fall) begin
            nak_n   = dat_f;
            state_n = WAIT_IDLE;
          end
          WAIT_IDLE: if (clk_f && dat_f) begin
            done_n    = 1'b1;
            ack_err_n = nak;
            state_n   = IDLE;
            cnt_n     = '0;
          end
          default: state_n = IDLE;
        endcase
        if (!fall && state_n != IDLE && cnt == TO_LAST) begin
          state_n   = IDLE;
          data_oe_n = 1'b0;
          to_n      = 1'b1;
          cnt_n     = '0;
        end
      end
    endcase
    // tx_ready is held off during the done/timeout pulse cycle so it rises one cycle later
    ready_n = (state_n == IDLE) && !done_n && !to_n;
    busy_n  = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      nak         <= 1'b0;
      shreg       <= '0;
      par         <= 1'b0;
      tx_ready    <= 1'b0;
      busy        <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      nak         <= nak_n;
      if (accept) begin
        shreg <= tx_data;
        par   <= ~^tx_data;
      end
      tx_ready    <= ready_n;
      busy        <= busy_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      done        <= done_n;
      ack_err     <= ack_err_n;
      timeout_err <= to_n;
    end
  end

endmodule
